mem_port_arbiter: RTL and testbench

//   Round-robin arbiter and sequencer for the single shared memory read port.

---
 rtl/arb_pkg.sv | 16 +
 rtl/mux_n.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and default sizes for the memory read-port arbiter.
// States, requester count and bus widths used across the slice.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT
  } arb_state_e;

  localparam int ARB_N_REQ  = 4;
  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_CNT_W  = 16;

endpackage

// File: rtl/mux_n.sv
// Parameterised N:1 mux over a packed bus of N equal-width fields.
// Field i sits at din[i*W +: W].
module mux_n #(
  parameter  int N     = 4,
  parameter  int W     = 32,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N*W-1:0]   din,
  input  logic [SEL_W-1:0] sel,
  output logic [W-1:0]     dout
);

  assign dout = din[sel*W +: W];

endmodule

// File: rtl/rr_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping.
// Purely combinational; any flags that some request is pending.
module rr_pick #(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [SEL_W:0] idx;

  // scan from farthest to nearest so the nearest set bit wins
  always_comb begin
    win = '0;
    idx = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (SEL_W+1)'(k);
      if (idx >= (SEL_W+1)'(N))
        idx = idx - (SEL_W+1)'(N);
      if (req[idx[SEL_W-1:0]])
        win = idx[SEL_W-1:0];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared memory read port.
// Optional per-requester grant counters: define ARB_PERF_CNT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter  int N_REQ  = ARB_N_REQ,
  parameter  int ADDR_W = ARB_ADDR_W,
  parameter  int DATA_W = ARB_DATA_W,
  parameter  int CNT_W  = ARB_CNT_W,
  localparam int SEL_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    bus_valid,
  output logic [ADDR_W-1:0]       bus_addr,
  input  logic                    bus_ready,
  input  logic                    bus_rvalid,
  input  logic [DATA_W-1:0]       bus_rdata,
  output logic [SEL_W-1:0]        grant_sel,
  output logic                    busy,
  output logic [N_REQ*CNT_W-1:0]  perf_grants
);

  arb_state_e       state;
  arb_state_e       state_nx;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] ptr_nx;
  logic [SEL_W-1:0] win;
  logic             any;
  logic             grant;
  logic [N_REQ-1:0] sel_oh;
  logic [ADDR_W-1:0] sel_addr;

  rr_pick #(
    .N (N_REQ)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  mux_n #(
    .N (N_REQ),
    .W (ADDR_W)
  ) u_mux (
    .din  (req_addr),
    .sel  (grant_sel),
    .dout (sel_addr)
  );

  assign grant  = (state == IDLE) && any;
  assign sel_oh = N_REQ'(1) << grant_sel;
  assign ptr_nx = (grant_sel == SEL_W'(N_REQ - 1))
                ? '0 : grant_sel + 1'b1;

  // next-state and handshake outputs
  always_comb begin
    state_nx  = state;
    bus_valid = 1'b0;
    bus_addr  = '0;
    req_ready = '0;
    busy      = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (any)
          state_nx = ADDR;
      end
      ADDR: begin
        bus_valid = 1'b1;
        bus_addr  = sel_addr;
        if (bus_ready) begin
          req_ready = sel_oh;
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        if (bus_rvalid)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state, grant, pointer and registered response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_sel <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= '0;
      if (grant)
        grant_sel <= win;
      if (state == WAIT && bus_rvalid) begin
        rsp_valid <= sel_oh;
        rsp_data  <= bus_rdata;
        ptr       <= ptr_nx;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    // saturating grant counter for requester i
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
        cnt <= '0;
      else if (grant && win == SEL_W'(i) && cnt != '1)
        cnt <= cnt + 1'b1;
    end

    assign perf_grants[i*CNT_W +: CNT_W] = cnt;
  end
`else
  assign perf_grants = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a reactive bus model.
// Build with ARB_PERF_CNT_EN to also check the grant counters.
module tb_mem_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  logic          clk;
  logic          resetn;
  logic [N-1:0]  req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          bus_valid;
  logic [AW-1:0] bus_addr;
  logic          bus_ready;
  logic          bus_rvalid;
  logic [DW-1:0] bus_rdata;
  logic [1:0]    grant_sel;
  logic          busy;
  logic [N*CW-1:0] perf_grants;

  logic [AW-1:0] addr [N];
  exp_t          sb [$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            ready_dly = 0;
  int            rv_dly    = 2;

  assign req_addr = {addr[3], addr[2], addr[1], addr[0]};

  mem_port_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .bus_valid   (bus_valid),
    .bus_addr    (bus_addr),
    .bus_ready   (bus_ready),
    .bus_rvalid  (bus_rvalid),
    .bus_rdata   (bus_rdata),
    .grant_sel   (grant_sel),
    .busy        (busy),
    .perf_grants (perf_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hDEAD_AEEF;
  endfunction

  // memory side: ready after ready_dly stall cycles, rdata rv_dly later
  task automatic bus_model();
    int m = 0;
    int cnt = 0;
    logic [31:0] acc = '0;
    forever begin
      @(posedge clk);
      #1;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      if (!resetn) begin
        m = 0;
        continue;
      end
      case (m)
        0: if (bus_valid) begin
          if (ready_dly == 0) begin
            bus_ready = 1'b1;
            acc = bus_addr;
            cnt = 0;
            m = 2;
          end else begin
            cnt = 1;
            m = 1;
          end
        end
        1: begin
          if (cnt == ready_dly) begin
            bus_ready = 1'b1;
            acc = bus_addr;
            cnt = 0;
            m = 2;
          end else begin
            cnt++;
          end
        end
        2: begin
          cnt++;
          if (cnt >= rv_dly) begin
            bus_rvalid = 1'b1;
            bus_rdata  = data_of(acc);
            m = 3;
          end
        end
        default: m = 0;
      endcase
    end
  endtask

  // pops the expected response whenever the DUT pulses rsp_valid
  task automatic monitor();
    exp_t e;
    logic [3:0] oh;
    forever begin
      @(negedge clk);
      if (resetn && rsp_valid !== 4'b0000) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid=%b with empty scoreboard",
                   rsp_valid);
        end else begin
          e  = sb.pop_front();
          oh = 4'b0001 << e.idx;
          if (rsp_valid !== oh) begin
            n_fail++;
            $display("FAIL rsp_valid: got %b want %b", rsp_valid, oh);
          end
          n_checks++;
          if (rsp_data !== e.data) begin
            n_fail++;
            $display("FAIL rsp_data: got %h want %h", rsp_data, e.data);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    ready_dly = 0;
    rv_dly    = 2;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ready(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b0;
    req_valid = '0;
    bus_ready = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    addr[0] = 32'h0000_1234;
    addr[1] = 32'h0;
    addr[2] = 32'h0;
    addr[3] = 32'h0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: busy=%b bus_valid=%b want 0 0",
               busy, bus_valid);
    end
    n_checks++;
    if (bus_addr !== '0 || grant_sel !== '0) begin
      n_fail++;
      $display("FAIL reset_sel: bus_addr=%h grant_sel=%0d want 0 0",
               bus_addr, grant_sel);
    end
    n_checks++;
    if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: req_ready=%b rsp_valid=%b rsp_data=%h want 0",
               req_ready, rsp_valid, rsp_data);
    end
    n_checks++;
    if (perf_grants !== '0) begin
      n_fail++;
      $display("FAIL reset_perf: got %h want 0", perf_grants);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || req_ready !== '0 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b req_ready=%b rsp_valid=%b want 0",
               busy, req_ready, rsp_valid);
    end
  endtask

  task automatic test_single();
    logic ok;
    do_reset();
    addr[0] = 32'h0000_1000;
    sb.push_back('{0, 32'hDEAD_BEEF});
    req_valid = 4'b0001;
    @(negedge clk);
    n_checks++;
    if (bus_valid !== 1'b1 || busy !== 1'b1 || grant_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL single_grant: bus_valid=%b busy=%b sel=%0d want 1 1 0",
               bus_valid, busy, grant_sel);
    end
    n_checks++;
    if (bus_addr !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL single_addr: got %h want 00001000", bus_addr);
    end
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_ready: got %b want 0001", req_ready);
    end
    req_valid = '0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_done: timeout, %0d responses pending", sb.size());
    end
  endtask

  task automatic test_round_robin();
    logic ok;
    int   grants;
    int   want;
    do_reset();
    for (int i = 0; i < N; i++)
      addr[i] = 32'h2000 + 32'(i) * 32'h100;
    for (int k = 0; k < 8; k++)
      sb.push_back('{k % N, data_of(addr[k % N])});
    grants = 0;
    req_valid = 4'hF;
    for (int c = 0; c < 120 && grants < 8; c++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000) begin
        want = grants % N;
        n_checks++;
        if (grant_sel !== 2'(want) || req_ready !== (4'b0001 << want)) begin
          n_fail++;
          $display("FAIL rr_order[%0d]: sel=%0d ready=%b want sel=%0d",
                   grants, grant_sel, req_ready, want);
        end
        grants++;
        if (grants == 8)
          req_valid = '0;
      end
    end
    n_checks++;
    if (grants != 8) begin
      n_fail++;
      $display("FAIL rr_count: got %0d grants want 8", grants);
      req_valid = '0;
    end
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rr_done: timeout, %0d responses pending", sb.size());
    end
    n_checks++;
`ifdef ARB_PERF_CNT_EN
    if (perf_grants !== {4{16'd2}}) begin
      n_fail++;
      $display("FAIL perf_grants: got %h want 0002 per field", perf_grants);
    end
`else
    if (perf_grants !== '0) begin
      n_fail++;
      $display("FAIL perf_grants: got %h want 0", perf_grants);
    end
`endif
  endtask

  task automatic test_wrap();
    logic ok;
    do_reset();
    addr[0] = 32'h0000_0040;
    addr[3] = 32'h0000_3000;
    sb.push_back('{3, data_of(32'h0000_3000)});
    req_valid = 4'b1000;
    wait_ready(ok);
    n_checks++;
    if (!ok || grant_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_first: ok=%b sel=%0d want 3", ok, grant_sel);
    end
    req_valid = '0;
    wait_idle(ok);
    sb.push_back('{0, data_of(32'h0000_0040)});
    sb.push_back('{3, data_of(32'h0000_3000)});
    req_valid = 4'b1001;
    wait_ready(ok);
    n_checks++;
    if (!ok || req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_req0: ready=%b want 0001", req_ready);
    end
    req_valid[0] = 1'b0;
    wait_ready(ok);
    n_checks++;
    if (!ok || req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_req3: ready=%b want 1000", req_ready);
    end
    req_valid = '0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wrap_done: timeout, %0d responses pending", sb.size());
    end
  endtask

  task automatic test_stall();
    logic ok;
    do_reset();
    ready_dly = 5;
    addr[2] = 32'hBFC0_0000;
    sb.push_back('{2, data_of(32'hBFC0_0000)});
    req_valid = 4'b0100;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus_valid !== 1'b1 || bus_addr !== 32'hBFC0_0000) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b addr=%h want 1 bfc00000",
                 k, bus_valid, bus_addr);
      end
      n_checks++;
      if (req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL stall_ready[%0d]: got %b want 0000", k, req_ready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL stall_accept: got %b want 0100", req_ready);
    end
    req_valid = '0;
    ready_dly = 0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_done: timeout, %0d responses pending", sb.size());
    end
  endtask

  task automatic test_reset_wait();
    logic ok;
    do_reset();
    rv_dly = 8;
    addr[0] = 32'h0000_0500;
    sb.push_back('{0, data_of(32'h0000_0500)});
    req_valid = 4'b0001;
    wait_ready(ok);
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (!ok || busy !== 1'b1 || bus_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_inwait: busy=%b bus_valid=%b want 1 0",
               busy, bus_valid);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || bus_valid !== 1'b0 || rsp_valid !== '0) begin
      n_fail++;
      $display("FAIL rstw_async: busy=%b bus_valid=%b rsp_valid=%b want 0",
               busy, bus_valid, rsp_valid);
    end
    sb.delete();
    @(negedge clk);
    resetn = 1'b1;
    rv_dly = 2;
    addr[1] = 32'h0000_0600;
    sb.push_back('{1, data_of(32'h0000_0600)});
    req_valid = 4'b0010;
    @(negedge clk);
    n_checks++;
    if (grant_sel !== 2'd1 || req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstw_regrant: sel=%0d ready=%b want 1 0010",
               grant_sel, req_ready);
    end
    req_valid = '0;
    wait_idle(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstw_done: timeout, %0d responses pending", sb.size());
    end
  endtask

  initial begin
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    resetn     = 1'b0;
    req_valid  = '0;
    fork
      bus_model();
      monitor();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_stall();
    test_reset_wait();
    repeat (4) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: %0d responses never seen", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
